// File: rtl/spi_mem_pkg.sv
// Shared opcodes, FSM state encoding and frame field positions for spi_mem_ctrl.
package spi_mem_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 8;
  localparam int PL_MSB = 7;
  localparam int PL_LSB = 0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrite  = 3'd1,
    StRdReq  = 3'd2,
    StRdWait = 3'd3,
    StTxHold = 3'd4
  } state_e;

endpackage

// File: rtl/spi_mem_sp.sv
// Single-port RAM with synchronous write and registered read data.
module spi_mem_sp #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Frame decoder and RAM access sequencer behind an SPI slave.
// Optional address auto-increment is enabled by defining SPI_MEM_AUTO_INC_EN.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 ss_n,
  output logic [DATA_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 err_seq,
  output logic                 err_ovr,
  input  logic                 err_clr
);

  state_e               state_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, mem_addr_q;
  logic                 rd_addr_vld_q, mem_we_q;
  logic [DATA_SIZE-1:0] mem_din_q, mem_dout, tx_data_q;
  logic                 tx_valid_q, err_seq_q, err_ovr_q;
  logic [1:0]           opcode;
  logic [7:0]           payload;

  assign opcode  = rx_data[OP_MSB:OP_LSB];
  assign payload = rx_data[PL_MSB:PL_LSB];

  function automatic logic [ADDR_SIZE-1:0] wrap(input logic [7:0] a);
    return ADDR_SIZE'(32'(a) % MEM_DEPTH);
  endfunction

`ifdef SPI_MEM_AUTO_INC_EN
  function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
    return (32'(a) + 32'd1 >= MEM_DEPTH) ? '0 : a + ADDR_SIZE'(1);
  endfunction
`endif

  spi_mem_sp #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) u_mem (
    .clk (clk),
    .we  (mem_we_q),
    .addr(mem_addr_q),
    .din (mem_din_q),
    .dout(mem_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_vld_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      err_seq_q     <= 1'b0;
      err_ovr_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      // Clear first so a same-cycle error event below takes precedence.
      if (err_clr) begin
        err_seq_q <= 1'b0;
        err_ovr_q <= 1'b0;
      end
      if (rx_valid && state_q != StIdle) begin
        err_ovr_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            unique case (opcode)
              OP_WR_ADDR: wr_addr_q <= wrap(payload);
              OP_WR_DATA: begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= wr_addr_q;
                mem_din_q  <= DATA_SIZE'(payload);
                state_q    <= StWrite;
`ifdef SPI_MEM_AUTO_INC_EN
                wr_addr_q  <= inc(wr_addr_q);
`endif
              end
              OP_RD_ADDR: begin
                rd_addr_q     <= wrap(payload);
                rd_addr_vld_q <= 1'b1;
              end
              OP_RD_DATA: begin
                if (rd_addr_vld_q) begin
                  mem_addr_q <= rd_addr_q;
                  state_q    <= StRdReq;
                end else begin
                  err_seq_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        StWrite: state_q <= StIdle;
        StRdReq: begin
`ifdef SPI_MEM_AUTO_INC_EN
          rd_addr_q <= inc(rd_addr_q);
`else
          rd_addr_vld_q <= 1'b0;
`endif
          // RAM read still completes this edge; an early ss_n just skips the hand-off.
          state_q <= ss_n ? StIdle : StRdWait;
        end
        StRdWait: begin
          tx_data_q <= mem_dout;
          if (ss_n) begin
            state_q <= StIdle;
          end else begin
            tx_valid_q <= 1'b1;
            state_q    <= StTxHold;
          end
        end
        StTxHold: begin
          if (ss_n) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != StIdle);
  assign err_seq  = err_seq_q;
  assign err_ovr  = err_ovr_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: vector table plus scoreboard of expected read bytes.
module tb_spi_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, rx_valid, ss_n, err_clr;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_valid, busy, err_seq, err_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  spi_mem_ctrl #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8),
    .DATA_SIZE(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .ss_n    (ss_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .busy    (busy),
    .err_seq (err_seq),
    .err_ovr (err_ovr),
    .err_clr (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [9:0] f);
    rx_data  = f;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!tx_valid && n < 8) begin
      tick(1);
      n++;
    end
    check("tx_valid_rise", {31'd0, tx_valid}, 1);
  endtask

  task automatic end_tx();
    ss_n = 1'b1;
    tick(1);
    check("tx_valid_drop", {31'd0, tx_valid}, 0);
    check("busy_after_ss", {31'd0, busy}, 0);
    ss_n = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    send({2'b00, a});
    send({2'b01, d});
    tick(1);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d);
    send({2'b10, a});
    exp_q.push_back(d);
    send(10'h300);
    wait_tx();
    end_tx();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_seq_cleared", {31'd0, err_seq}, 0);
    check("err_ovr_cleared", {31'd0, err_ovr}, 0);
  endtask

  // Scoreboard: every rising tx_valid must deliver the oldest expected byte.
  initial begin
    logic tv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_valid && !tv_prev) begin
        if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_data_sb", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      tv_prev = tx_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{addr: 8'h10, data: 8'h55};
    vecs[1] = '{addr: 8'h11, data: 8'hAA};
    vecs[2] = '{addr: 8'h80, data: 8'h01};
    vecs[3] = '{addr: 8'h7F, data: 8'h3C};
    vecs[4] = '{addr: 8'hC3, data: 8'hE7};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; ss_n = 1'b0; err_clr = 1'b0;
    tick(2);
    check("rst_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err_seq", {31'd0, err_seq}, 0);
    check("rst_err_ovr", {31'd0, err_ovr}, 0);
    rst_n = 1'b1;
    tick(1);

    // Write then read back with exact latency.
    wr(8'h3A, 8'hC5);
    send(10'h23A);
    exp_q.push_back(8'hC5);
    send(10'h300);
    check("busy_rd_req", {31'd0, busy}, 1);
    tick(1);
    check("tx_not_early", {31'd0, tx_valid}, 0);
    tick(1);
    check("tx_latency", {31'd0, tx_valid}, 1);
    check("tx_data_c5", {24'd0, tx_data}, 8'hC5);
    end_tx();
    check("tx_data_kept", {24'd0, tx_data}, 8'hC5);

    // Vector table: write all, read back in reverse.
    foreach (vecs[i]) wr(vecs[i].addr, vecs[i].data);
    for (int i = 4; i >= 0; i--) rd(vecs[i].addr, vecs[i].data);
    // Last address latched twice: the second one wins.
    send({2'b10, 8'h10});
    exp_q.push_back(8'h01);
    send({2'b10, 8'h80});
    send(10'h300);
    wait_tx();
    end_tx();

`ifndef SPI_MEM_AUTO_INC_EN
    send(10'h300);
    check("vld_cleared_after_read", {31'd0, err_seq}, 1);
    clear_errs();
`endif

    // Sequence error after reset, and err_clr losing to a same-cycle event.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    send(10'h300);
    check("seq_err_set", {31'd0, err_seq}, 1);
    check("seq_err_busy", {31'd0, busy}, 0);
    tick(3);
    check("seq_err_no_tx", {31'd0, tx_valid}, 0);
    clear_errs();
    err_clr = 1'b1;
    send(10'h300);
    err_clr = 1'b0;
    check("err_event_beats_clr", {31'd0, err_seq}, 1);
    clear_errs();

    // Overrun during TX_HOLD.
    wr(8'h40, 8'h5A);
    send(10'h240);
    exp_q.push_back(8'h5A);
    send(10'h300);
    wait_tx();
    send(10'h1FF);
    check("ovr_set", {31'd0, err_ovr}, 1);
    check("ovr_tx_held", {24'd0, tx_data}, 8'h5A);
    check("ovr_tx_valid", {31'd0, tx_valid}, 1);
    end_tx();
    rd(8'h40, 8'h5A);
    clear_errs();

    // Reset in RD_WAIT.
    send(10'h240);
    send(10'h300);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    send(10'h300);
    check("rst_mid_vld_cleared", {31'd0, err_seq}, 1);
    clear_errs();

    // Early ss_n during RD_REQ.
    send(10'h240);
    send(10'h300);
    ss_n = 1'b1;
    tick(1);
    check("early_ss_idle", {31'd0, busy}, 0);
    tick(1);
    check("early_ss_no_tx", {31'd0, tx_valid}, 0);
    ss_n = 1'b0;
    tick(1);

`ifdef SPI_MEM_AUTO_INC_EN
    send(10'h0FF);
    send(10'h111);
    tick(1);
    send(10'h122);
    tick(1);
    send(10'h2FF);
    exp_q.push_back(8'h11);
    send(10'h300);
    wait_tx();
    end_tx();
    exp_q.push_back(8'h22);
    send(10'h300);
    wait_tx();
    end_tx();
    check("auto_no_seq_err", {31'd0, err_seq}, 0);
`endif

    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
